// File: rtl/mem_dma_if.sv
// mem_dma_if: native PicoRV32-style memory bus bundle.
//
// Handshake: the initiator raises valid together with addr/wdata/wstrb and
// holds all four constant until it samples ready=1 on a rising edge; that
// edge completes the transfer. wstrb=0 means read, in which case rdata is
// valid in the cycle ready=1. The responder drives ready high for exactly
// one cycle per transfer.
//
// Signals: valid, ready, addr[ADDR_W-1:0], wdata[31:0], wstrb[3:0], rdata[31:0]
// Modports: master = initiator side, slave = responder side.
interface mem_dma_if #(
  parameter int ADDR_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic [31:0]       rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_dma.sv
// mem_dma: word-copy DMA engine.
// Copies LEN 32-bit words from SRC to DST over the memory bus (one read
// beat followed by one write beat per word) and pulses irq_done at the end.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   cfg        register port (responder): 0x0 SRC, 0x4 DST, 0x8 LEN, 0xC CTRL
//              CTRL write: bit0 START, bit2 DONE (W1C), bit3 ABORT
//              CTRL read : bit1 busy, bit2 done
//   mem        memory bus (initiator)
//   irq_done   one-cycle pulse when a transfer ends (normal or aborted)
//   dbg_state  current FSM state (0 IDLE, 1 RD, 2 WR, 3 FIN)
module mem_dma #(
  parameter int LEN_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  mem_dma_if.slave    cfg,
  mem_dma_if.master   mem,
  output logic        irq_done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  state_t               state, state_d;
  logic [31:0]          src_q, dst_q;
  logic [LEN_WIDTH-1:0] len_q, cnt_q;
  logic [31:0]          src_cur, dst_cur, buf_q;
  logic                 done_q, abort_pend, cfg_ready_q, mem_valid_q;

  logic        busy, cfg_wr, ctrl_wr, start_req, abort_req, clr_done;
  logic        mem_fire, rd_fire, wr_fire;
  logic [31:0] src_merged, dst_merged, len_merged;
  logic        unused_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign busy      = (state == ST_RD) || (state == ST_WR);
  // A write commits on the edge that ends the cycle in which cfg_ready is high.
  assign cfg_wr    = cfg_ready_q && cfg.valid && (cfg.wstrb != 4'h0);
  assign ctrl_wr   = cfg_wr && (cfg.addr[3:2] == 2'd3) && cfg.wstrb[0];
  assign start_req = ctrl_wr && cfg.wdata[0] && !busy;
  assign clr_done  = ctrl_wr && cfg.wdata[2];
  assign abort_req = ctrl_wr && cfg.wdata[3] && busy;

  assign mem_fire  = mem_valid_q && mem.ready;
  assign rd_fire   = mem_fire && (state == ST_RD);
  assign wr_fire   = mem_fire && (state == ST_WR);

  assign src_merged = merge_bytes(src_q, cfg.wdata, cfg.wstrb) & 32'hFFFF_FFFC;
  assign dst_merged = merge_bytes(dst_q, cfg.wdata, cfg.wstrb) & 32'hFFFF_FFFC;
  assign len_merged = merge_bytes({{(32-LEN_WIDTH){1'b0}}, len_q}, cfg.wdata, cfg.wstrb);
  assign unused_bits = ^{cfg.addr[1:0], len_merged[31:LEN_WIDTH]};

  always_comb begin
    state_d = state;
    case (state)
      // FIN has busy=0, so a START landing there is honoured like in IDLE.
      ST_IDLE, ST_FIN: begin
        if (start_req) state_d = (len_q == '0) ? ST_FIN : ST_RD;
        else           state_d = ST_IDLE;
      end
      ST_RD: if (rd_fire) state_d = ST_WR;
      ST_WR: begin
        if (wr_fire) begin
          if ((cnt_q == LEN_WIDTH'(1)) || abort_pend || abort_req) state_d = ST_FIN;
          else                                                      state_d = ST_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      src_cur     <= '0;
      dst_cur     <= '0;
      buf_q       <= '0;
      done_q      <= 1'b0;
      abort_pend  <= 1'b0;
      cfg_ready_q <= 1'b0;
      mem_valid_q <= 1'b0;
    end else begin
      state       <= state_d;
      cfg_ready_q <= cfg.valid && !cfg_ready_q;
      // Dropping valid on every completing beat guarantees the one-cycle gap.
      mem_valid_q <= ((state_d == ST_RD) || (state_d == ST_WR)) && !mem_fire;

      if (cfg_wr && !busy) begin
        case (cfg.addr[3:2])
          2'd0:    src_q <= src_merged;
          2'd1:    dst_q <= dst_merged;
          2'd2:    len_q <= len_merged[LEN_WIDTH-1:0];
          default: ;
        endcase
      end

      if (start_req && (len_q != '0)) begin
        src_cur <= src_q;
        dst_cur <= dst_q;
        cnt_q   <= len_q;
      end

      if (start_req)      abort_pend <= 1'b0;
      else if (abort_req) abort_pend <= 1'b1;

      if (state_d == ST_FIN) done_q <= 1'b1;
      else if (clr_done)     done_q <= 1'b0;

      if (rd_fire) buf_q <= mem.rdata;

      if (wr_fire) begin
        src_cur <= src_cur + 32'd4;
        dst_cur <= dst_cur + 32'd4;
        if (cnt_q != '0) cnt_q <= cnt_q - LEN_WIDTH'(1);
      end
    end
  end

  assign cfg.ready = cfg_ready_q;

  always_comb begin
    cfg.rdata = 32'h0;
    if (cfg_ready_q) begin
      case (cfg.addr[3:2])
        2'd0:    cfg.rdata = src_q;
        2'd1:    cfg.rdata = dst_q;
        2'd2:    cfg.rdata = {{(32-LEN_WIDTH){1'b0}}, len_q};
        default: cfg.rdata = {29'h0, done_q, busy, 1'b0};
      endcase
    end
  end

  // Bus fields are zero whenever no request is outstanding.
  assign mem.valid = mem_valid_q;
  assign mem.addr  = !mem_valid_q ? 32'h0 : (state == ST_WR) ? dst_cur : src_cur;
  assign mem.wdata = (mem_valid_q && (state == ST_WR)) ? buf_q : 32'h0;
  assign mem.wstrb = (mem_valid_q && (state == ST_WR)) ? 4'hF : 4'h0;

  assign irq_done  = (state == ST_FIN);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_dma.sv
module tb_mem_dma;

  logic       clk = 1'b0;
  logic       reset;
  logic       irq_done;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  mem_dma_if #(.ADDR_W(4))  cfg_bus ();
  mem_dma_if #(.ADDR_W(32)) mem_bus ();

  mem_dma #(.LEN_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg       (cfg_bus),
    .mem       (mem_bus),
    .irq_done  (irq_done),
    .dbg_state (dbg_state)
  );

  localparam logic [3:0] A_SRC = 4'h0, A_DST = 4'h4, A_LEN = 4'h8, A_CTRL = 4'hC;

  int checks = 0;
  int errors = 0;

  // {wstrb, addr, data}; data is 0 for reads
  logic [67:0] exp_q[$];
  logic [31:0] mem_init [logic [31:0]];

  int          wait_cycles = 0;
  logic        stall_en = 1'b0;
  logic [31:0] stall_addr = 32'h0;
  bit          in_beat = 0;
  logic [67:0] cap;
  int          wcnt = 0;
  int          beats = 0, wr_beats = 0, valid_cycles = 0, irq_cnt = 0;

  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_init.exists(a)) return mem_init[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] sa, da;
    for (int i = 0; i < n; i++) begin
      sa = s + 32'(4 * i);
      da = d + 32'(4 * i);
      exp_q.push_back({4'h0, sa, 32'h0});
      exp_q.push_back({4'hF, da, mem_word(sa)});
    end
  endtask

  // Memory responder and monitors, sampled on the falling edge.
  initial begin
    logic [67:0] cur, obs, e;
    mem_bus.ready = 1'b0;
    mem_bus.rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (irq_done) irq_cnt++;
      if (mem_bus.valid) valid_cycles++;
      cur = {mem_bus.wstrb, mem_bus.addr, mem_bus.wdata};
      if (mem_bus.ready) begin
        mem_bus.ready = 1'b0;
        mem_bus.rdata = 32'h0;
        in_beat = 0;
        check("valid_gap", 68'(mem_bus.valid), 68'(0));
      end else if (mem_bus.valid) begin
        if (!in_beat) begin
          in_beat = 1;
          cap = cur;
          wcnt = 0;
        end else begin
          check("bus_stable", cur, cap);
        end
        if (!(stall_en && mem_bus.addr == stall_addr)) begin
          if (wcnt >= wait_cycles) begin
            obs = {mem_bus.wstrb, mem_bus.addr, (mem_bus.wstrb == 4'h0) ? 32'h0 : mem_bus.wdata};
            if (exp_q.size() == 0) begin
              check("extra_beat", obs, 68'(0));
            end else begin
              e = exp_q.pop_front();
              check("beat", obs, e);
            end
            if (mem_bus.wstrb == 4'h0) mem_bus.rdata = mem_word(mem_bus.addr);
            else wr_beats++;
            mem_bus.ready = 1'b1;
            beats++;
          end else begin
            wcnt++;
          end
        end
      end else begin
        in_beat = 0;
      end
    end
  end

  task automatic cfg_access(input logic [3:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd);
    int n = 0;
    cfg_bus.valid = 1'b1;
    cfg_bus.addr  = a;
    cfg_bus.wdata = d;
    cfg_bus.wstrb = s;
    rd = 32'h0;
    forever begin
      @(negedge clk);
      if (cfg_bus.ready) begin
        rd = cfg_bus.rdata;
        break;
      end
      n++;
      if (n > 20) begin
        check("cfg_timeout", 68'(0), 68'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    cfg_bus.valid = 1'b0;
    cfg_bus.wstrb = 4'h0;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    cfg_access(a, d, 4'hF, dummy);
  endtask

  task automatic cfg_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    cfg_access(a, 32'h0, 4'h0, rd);
    check(tag, 68'(rd), 68'(exp));
  endtask

  task automatic wait_irq(input int base, input int budget);
    int n = 0;
    while (irq_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("irq_seen", 68'(irq_cnt != base), 68'(1));
  endtask

  task automatic wait_bus(input logic [31:0] a, input logic [3:0] strb, input int budget);
    int n = 0;
    while (!(mem_bus.valid && mem_bus.addr == a && mem_bus.wstrb == strb) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("bus_reached", 68'(n < budget), 68'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, b0, w0, v0;
    reset = 1'b1;
    cfg_bus.valid = 1'b0;
    cfg_bus.addr  = 4'h0;
    cfg_bus.wdata = 32'h0;
    cfg_bus.wstrb = 4'h0;
    mem_init[32'h4000] = 32'h11;
    mem_init[32'h4004] = 32'h22;
    mem_init[32'h4008] = 32'h33;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_mem_valid", 68'(mem_bus.valid), 68'(0));
    check("rst_irq", 68'(irq_done), 68'(0));
    check("rst_cfg_ready", 68'(cfg_bus.ready), 68'(0));
    check("rst_state", 68'(dbg_state), 68'(0));
    cfg_check("rst_src", A_SRC, 32'h0);
    cfg_check("rst_dst", A_DST, 32'h0);
    cfg_check("rst_len", A_LEN, 32'h0);
    cfg_check("rst_ctrl", A_CTRL, 32'h0);

    // 1: basic 3-word copy, zero-wait memory
    cfg_write(A_SRC, 32'h4000);
    cfg_write(A_DST, 32'h5000);
    cfg_write(A_LEN, 32'd3);
    cfg_check("len_rb", A_LEN, 32'd3);
    push_copy(32'h4000, 32'h5000, 3);
    base = irq_cnt;
    cfg_write(A_CTRL, 32'h1);
    wait_irq(base, 200);
    repeat (3) @(negedge clk);
    check("t1_q_empty", 68'(exp_q.size()), 68'(0));
    check("t1_one_irq", 68'(irq_cnt - base), 68'(1));
    cfg_check("t1_ctrl", A_CTRL, 32'h4);

    // 2: LEN=0 finishes without bus traffic
    cfg_write(A_LEN, 32'd0);
    v0 = valid_cycles;
    base = irq_cnt;
    cfg_write(A_CTRL, 32'h1);
    repeat (2) @(negedge clk);
    check("t2_irq_2cyc", 68'(irq_cnt - base), 68'(1));
    check("t2_no_valid", 68'(valid_cycles - v0), 68'(0));
    cfg_check("t2_ctrl_done", A_CTRL, 32'h4);
    cfg_write(A_CTRL, 32'h4);
    cfg_check("t2_ctrl_clr", A_CTRL, 32'h0);

    // 3: slow memory, 5 wait cycles per beat
    wait_cycles = 5;
    cfg_write(A_SRC, 32'h6000);
    cfg_write(A_DST, 32'h7000);
    cfg_write(A_LEN, 32'd2);
    push_copy(32'h6000, 32'h7000, 2);
    b0 = beats;
    base = irq_cnt;
    cfg_write(A_CTRL, 32'h1);
    wait_irq(base, 300);
    check("t3_beats", 68'(beats - b0), 68'(4));
    check("t3_q_empty", 68'(exp_q.size()), 68'(0));

    // 4: abort during the second read
    wait_cycles = 3;
    cfg_write(A_SRC, 32'h8000);
    cfg_write(A_DST, 32'h9000);
    cfg_write(A_LEN, 32'd100);
    push_copy(32'h8000, 32'h9000, 2);
    w0 = wr_beats;
    base = irq_cnt;
    cfg_write(A_CTRL, 32'h5);
    wait_bus(32'h8004, 4'h0, 200);
    cfg_write(A_CTRL, 32'h8);
    wait_irq(base, 300);
    repeat (10) @(negedge clk);
    check("t4_words", 68'(wr_beats - w0), 68'(2));
    check("t4_q_empty", 68'(exp_q.size()), 68'(0));
    cfg_check("t4_ctrl", A_CTRL, 32'h4);

    // 5: register writes and START while busy are ignored
    wait_cycles = 2;
    cfg_write(A_SRC, 32'hA000);
    cfg_write(A_DST, 32'hB000);
    cfg_write(A_LEN, 32'd4);
    push_copy(32'hA000, 32'hB000, 4);
    base = irq_cnt;
    cfg_write(A_CTRL, 32'h5);
    cfg_write(A_SRC, 32'h1234);
    cfg_write(A_CTRL, 32'h1);
    cfg_check("t5_src_busy", A_SRC, 32'hA000);
    cfg_check("t5_ctrl_busy", A_CTRL, 32'h2);
    wait_irq(base, 400);
    repeat (20) @(negedge clk);
    check("t5_one_irq", 68'(irq_cnt - base), 68'(1));
    check("t5_q_empty", 68'(exp_q.size()), 68'(0));
    cfg_write(A_SRC, 32'h7);
    cfg_check("t5_src_align", A_SRC, 32'h4);

    // 6: address wrap, then reset during a stalled write
    wait_cycles = 0;
    stall_en = 1'b1;
    stall_addr = 32'hC004;
    cfg_write(A_CTRL, 32'h4);
    cfg_write(A_SRC, 32'hFFFF_FFFC);
    cfg_write(A_DST, 32'hC000);
    cfg_write(A_LEN, 32'd2);
    push_copy(32'hFFFF_FFFC, 32'hC000, 2);
    cfg_write(A_CTRL, 32'h1);
    wait_bus(32'hC004, 4'hF, 200);
    repeat (2) @(negedge clk);
    base = irq_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_valid_drop", 68'(mem_bus.valid), 68'(0));
    check("t6_state_idle", 68'(dbg_state), 68'(0));
    repeat (3) @(negedge clk);
    check("t6_no_irq", 68'(irq_cnt - base), 68'(0));
    check("t6_pending_wr", 68'(exp_q.size()), 68'(1));
    exp_q.delete();
    stall_en = 1'b0;
    cfg_check("t6_ctrl", A_CTRL, 32'h0);
    cfg_check("t6_src_rst", A_SRC, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_dma.md
Name: mem_dma

Overview:
- Word-copy DMA engine; acts as an initiator on the native PicoRV32 memory bus (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata), on a second initiator port of the SoC interconnect.
- CPU programs it through a small responder register port (cfg_*) using the same valid/ready protocol.
- Copies LEN 32-bit words from SRC to DST and raises a done interrupt.

Parameters:
LEN_WIDTH  16  width of the word-count register; max transfer is 2^LEN_WIDTH-1 words.

Ports:
clk        input   1          system clock, all logic on rising edge
reset      input   1          synchronous, active-high reset
cfg_valid  input   1          register access request
cfg_ready  output  1          register access complete (1-cycle pulse)
cfg_addr   input   4          byte offset: 0x0 SRC, 0x4 DST, 0x8 LEN, 0xC CTRL
cfg_wdata  input   32         register write data
cfg_wstrb  input   4          byte write strobes; 0 = read
cfg_rdata  output  32         register read data, valid while cfg_ready=1
mem_valid  output  1          bus request
mem_ready  input   1          bus completion
mem_addr   output  32         word-aligned bus address
mem_wdata  output  32         write data
mem_wstrb  output  4          4'hF on write, 4'h0 on read
mem_rdata  input   32         read data, sampled when mem_ready=1
irq_done   output  1          1-cycle pulse when a transfer ends

Behaviour:
Reset:
- All outputs 0. SRC, DST and LEN are 0. FSM is IDLE. busy=0, done=0.

Register port:
- cfg_ready is registered: cfg_ready <= cfg_valid && !cfg_ready. Read data is presented in the same cycle as cfg_ready.
- A write commits on the cycle cfg_ready is high, honouring per-byte strobes. Write data must stay stable until then.
- SRC and DST bits [1:0] always read as 0. LEN reads zero-extended.
- CTRL write bits:
  - bit0 START: ignored if busy=1.
  - bit2 DONE: write-1-to-clear.
  - bit3 ABORT: ignored if busy=0.
- CTRL read bits: bit1 busy, bit2 done. All other bits read 0.
- Writes to SRC, DST or LEN while busy=1 are ignored.
- If START and DONE-clear arrive in the same write, done is cleared and the transfer starts.
- Unmapped bits are ignored. cfg_addr[1:0] is ignored.

FSM states: IDLE, RD, WR, FIN.
- IDLE, START with LEN=0:
  - Go to FIN. No bus traffic.
- IDLE, START with LEN>0:
  - Copy SRC, DST and LEN into working counters. busy=1. Go to RD.
- RD:
  - mem_valid=1, mem_addr=src_cur, mem_wstrb=0.
  - On mem_ready: latch mem_rdata into a buffer, drop mem_valid on the next cycle, go to WR.
- WR:
  - mem_valid=1, mem_addr=dst_cur, mem_wdata=buffer, mem_wstrb=4'hF.
  - On mem_ready: src_cur+=4, dst_cur+=4, cnt-=1.
  - If cnt was 1, or an abort is pending, go to FIN. Otherwise go to RD.
- FIN:
  - busy=0, done=1, irq_done=1 for exactly one cycle. Return to IDLE.

Bus rules:
- mem_valid, mem_addr, mem_wdata and mem_wstrb stay constant from assertion until the cycle mem_ready is sampled high.
- mem_valid is 0 for at least one cycle between transactions.
- There is no latency bound on mem_ready. The engine waits indefinitely.

Abort:
- Latched as pending. It takes effect only at the completion of a WR beat, never mid-transaction.
- The in-flight read or write always completes.
- done=1 on abort as well.

Arithmetic:
- Address increments wrap modulo 2^32 (0xFFFF_FFFC + 4 = 0).
- The working count never underflows.

Architectural registers:
- SRC, DST and LEN are not modified by a transfer. Re-issuing START repeats the same copy.

Reset mid-transfer:
- mem_valid drops on the next edge. The FSM returns to IDLE and no irq_done is generated.

Simultaneous events:
- A cfg access and a bus beat completing in the same cycle are independent. Status reads show the pre-edge value.

Test Plan:
1. SRC=0x4000, DST=0x5000, LEN=3, START; zero-wait memory returns 0x11,0x22,0x33. Required: bus sequence RD 0x4000, WR 0x5000=0x11, RD 0x4004, WR 0x5004=0x22, RD 0x4008, WR 0x5008=0x33, then one irq_done pulse. CTRL reads 0x4.
2. LEN=0, START. Required: no mem_valid assertion, irq_done within 2 cycles, done=1. Then write CTRL=0x4. Required: CTRL reads 0.
3. LEN=2, mem_ready delayed 5 cycles per beat. Required: addr, wdata and wstrb stable throughout each wait, mem_valid low for at least 1 cycle between beats, 4 beats total.
4. LEN=100, ABORT written during the 2nd RD. Required: that RD and its WR complete, then FIN. Exactly 2 words are written, done=1, busy=0.
5. Write SRC=0x1234 and START while busy. Required: SRC readback is unchanged and the current transfer is unaffected. SRC=0x7 written while idle reads back 0x4.
6. SRC=0xFFFF_FFFC, LEN=2. Required: second RD is at 0x0000_0000. Assert reset during a WR wait. Required: mem_valid=0 next cycle, busy=0, no irq_done.
